// File: rtl/adder_pkg.sv
// Shared add/sub definitions for the datapath blocks.
// Mode encoding and the signed overflow rule.
package adder_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic logic ovf_rule(
    input logic a_msb,
    input logic b_msb,
    input logic s_msb
  );
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/adder_stage.sv
// One carry-chain slice of the pipelined adder.
// Registers the slice sum, its carry-out and the beat valid.
module adder_stage
  import adder_pkg::*;
#(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          valid_i,
  input  logic [CW-1:0] a_i,
  input  logic [CW-1:0] b_i,
  input  logic          c_i,
  output logic          valid_o,
  output logic [CW-1:0] sum_o,
  output logic          c_o
);

  logic          valid_q, valid_d;
  logic          c_q, c_d;
  logic [CW-1:0] sum_q, sum_d;
  logic [CW:0]   add;

  always_comb begin
    add     = {1'b0, a_i} + {1'b0, b_i}
            + {{CW{1'b0}}, c_i};
    valid_d = valid_q;
    sum_d   = sum_q;
    c_d     = c_q;
    if (en) begin
      valid_d = valid_i;
      sum_d   = add[CW-1:0];
      c_d     = add[CW];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      sum_q   <= '0;
      c_q     <= 1'b0;
    end else begin
      valid_q <= valid_d;
      sum_q   <= sum_d;
      c_q     <= c_d;
    end
  end

  assign valid_o = valid_q;
  assign sum_o   = sum_q;
  assign c_o     = c_q;

endmodule

// File: rtl/pipe_adder.sv
// Pipelined SIZE-bit add/subtract, STAGES carry slices,
// valid/ready on both sides with a global advance enable.
module pipe_adder
  import adder_pkg::*;
#(
  parameter int SIZE   = 32,
  parameter int STAGES = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic            cin,
  input  logic            sub,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] sum,
  output logic            cout,
  output logic            ovf
);

  localparam int CW = SIZE / STAGES;

  if (STAGES < 1 || STAGES > SIZE || (SIZE % STAGES) != 0)
  begin : g_bad_cfg
    $error("pipe_adder: bad SIZE/STAGES");
  end

  logic                       en;
  logic [SIZE-1:0]            b_eff;
  logic                       c_eff;
  logic [STAGES-1:0]          op_v, op_c;
  logic [STAGES-1:0]          st_v, st_c;
  logic [STAGES-1:0][CW-1:0]  op_a, op_b, st_s;
  logic [1:0]                 msb_q, msb_d;

  assign en       = !st_v[STAGES-1] || out_ready;
  assign in_ready = en;
  assign b_eff    = (sub == OP_SUB) ? ~b : b;
  assign c_eff    = (sub == OP_ADD) ? cin : 1'b1;

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int W = SIZE - k * CW;
    // a_up/b_up: operand bits k*CW and up, aligned to stage k
    logic [W-1:0]         a_up, b_up;
    logic [(k+1)*CW-1:0]  res;

    if (k == 0) begin : g_in
      assign a_up    = a;
      assign b_up    = b_eff;
      assign op_v[0] = in_valid;
      assign op_c[0] = c_eff;
      assign res     = st_s[0];
    end else begin : g_sk
      logic [W-1:0]      a_q, a_d, b_q, b_d;
      logic [k*CW-1:0]   lo_q, lo_d;

      always_comb begin
        a_d  = a_q;
        b_d  = b_q;
        lo_d = lo_q;
        if (en) begin
          a_d  = g_st[k-1].a_up[W+CW-1:CW];
          b_d  = g_st[k-1].b_up[W+CW-1:CW];
          lo_d = g_st[k-1].res;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q  <= '0;
          b_q  <= '0;
          lo_q <= '0;
        end else begin
          a_q  <= a_d;
          b_q  <= b_d;
          lo_q <= lo_d;
        end
      end

      assign a_up    = a_q;
      assign b_up    = b_q;
      assign op_v[k] = st_v[k-1];
      assign op_c[k] = st_c[k-1];
      assign res     = {st_s[k], lo_q};
    end

    assign op_a[k] = a_up[CW-1:0];
    assign op_b[k] = b_up[CW-1:0];

    adder_stage #(.CW(CW)) u_stage (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .valid_i (op_v[k]),
      .a_i     (op_a[k]),
      .b_i     (op_b[k]),
      .c_i     (op_c[k]),
      .valid_o (st_v[k]),
      .sum_o   (st_s[k]),
      .c_o     (st_c[k])
    );
  end

  // Operand sign bits ride with the final slice for ovf
  always_comb begin
    msb_d = msb_q;
    if (en)
      msb_d = {op_a[STAGES-1][CW-1], op_b[STAGES-1][CW-1]};
  end

  always_ff @(posedge clk) begin
    if (rst) msb_q <= 2'b00;
    else     msb_q <= msb_d;
  end

  assign out_valid = st_v[STAGES-1];
  assign cout      = st_c[STAGES-1];
  assign sum       = g_st[STAGES-1].res;
  assign ovf       = ovf_rule(msb_q[1], msb_q[0], sum[SIZE-1]);

endmodule

// File: tb/tb_pipe_adder.sv
// Scoreboard bench for pipe_adder at STAGES = 4, 1 and 32.
// Index 0: STAGES=4, 1: STAGES=1, 2: STAGES=32.
module tb_pipe_adder;

  typedef struct packed {
    logic [31:0] s;
    logic        c;
    logic        o;
    logic [31:0] t;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iv[3], ir[3], cin_s[3], sub_s[3];
  logic        ov[3], ordy[3], co[3], of[3];
  logic [31:0] av[3], bv[3], sm[3];

  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] cyc = 0;
  bit          chk_lat = 0;
  bit          rnd_done = 0;
  exp_t        q[3][$];
  exp_t        pend[3];
  exp_t        me;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pipe_adder #(.SIZE(32), .STAGES(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
    .a(av[0]), .b(bv[0]), .cin(cin_s[0]), .sub(sub_s[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .sum(sm[0]),
    .cout(co[0]), .ovf(of[0]));

  pipe_adder #(.SIZE(32), .STAGES(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
    .a(av[1]), .b(bv[1]), .cin(cin_s[1]), .sub(sub_s[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .sum(sm[1]),
    .cout(co[1]), .ovf(of[1]));

  pipe_adder #(.SIZE(32), .STAGES(32)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
    .a(av[2]), .b(bv[2]), .cin(cin_s[2]), .sub(sub_s[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .sum(sm[2]),
    .cout(co[2]), .ovf(of[2]));

  function automatic int stg(input int d);
    return (d == 0) ? 4 : ((d == 1) ? 1 : 32);
  endfunction

  function automatic exp_t mk(input logic [31:0] s,
                              input logic c, input logic o);
    exp_t e;
    e.s = s; e.c = c; e.o = o; e.t = '0;
    return e;
  endfunction

  function automatic exp_t model(input logic [31:0] x, y,
                                 input logic c, s);
    logic [32:0] r;
    if (s) begin
      r = {1'b0, x} - {1'b0, y};
      return mk(r[31:0], ~r[32],
                (x[31] != y[31]) && (r[31] != x[31]));
    end
    r = {1'b0, x} + {1'b0, y} + {32'd0, c};
    return mk(r[31:0], r[32],
              (x[31] == y[31]) && (r[31] != x[31]));
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 3; d++) begin
        if (iv[d] && ir[d]) begin
          me   = pend[d];
          me.t = cyc;
          q[d].push_back(me);
        end
        if (ov[d] && ordy[d]) begin
          if (q[d].size() == 0) begin
            chk($sformatf("spurious_out%0d", d), 1, 0);
          end else begin
            me = q[d].pop_front();
            chk($sformatf("sum%0d", d), sm[d], me.s);
            chk($sformatf("cout%0d", d), co[d], me.c);
            chk($sformatf("ovf%0d", d), of[d], me.o);
            if (chk_lat)
              chk($sformatf("latency%0d", d), cyc - me.t, stg(d));
          end
        end
      end
    end
  end

  task automatic send(input int d,
                      input logic [31:0] x, y,
                      input logic c, s,
                      input exp_t e,
                      output int w);
    w = 0;
    iv[d] = 1'b1; av[d] = x; bv[d] = y;
    cin_s[d] = c; sub_s[d] = s; pend[d] = e;
    do begin
      @(negedge clk);
      w++;
    end while (!ir[d] && w < 200);
    if (!ir[d]) chk("send_timeout", 0, 1);
    @(posedge clk); #1;
    iv[d] = 1'b0;
  endtask

  task automatic drain(input int d);
    int n = 0;
    while (q[d].size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("drain%0d", d), q[d].size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic rand_run(input int d);
    logic [31:0] x, y;
    logic        c, s;
    int          w;
    rnd_done = 0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
          x = $urandom; y = $urandom;
          c = 1'($urandom_range(0, 1));
          s = 1'($urandom_range(0, 1));
          send(d, x, y, c, s, model(x, y, c, s), w);
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          ordy[d] = 1'($urandom_range(0, 1));
        end
      end
    join
    ordy[d] = 1'b1;
    drain(d);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int          w;
    logic [31:0] s_snap;
    logic        c_snap, o_snap;

    for (int d = 0; d < 3; d++) begin
      iv[d] = 0; av[d] = '0; bv[d] = '0;
      cin_s[d] = 0; sub_s[d] = 0; ordy[d] = 1;
      pend[d] = mk('0, 0, 0);
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("rst_out_valid", ov[d], 0);
      chk("rst_sum", sm[d], 0);
      chk("rst_cout", co[d], 0);
      chk("rst_ovf", of[d], 0);
      chk("rst_in_ready", ir[d], 1);
    end
    @(posedge clk); #1;

    chk_lat = 1;
    send(0, 32'hFFFF_FFFF, 32'h1, 0, 0, mk(32'h0, 1, 0), w);
    send(0, 32'h7FFF_FFFF, 32'h1, 0, 0, mk(32'h8000_0000, 0, 1), w);
    send(0, 32'h3, 32'h4, 1, 0, mk(32'h8, 0, 0), w);
    send(0, 32'h5, 32'h7, 1, 1, mk(32'hFFFF_FFFE, 0, 0), w);
    send(0, 32'h8000_0000, 32'h1, 1, 1, mk(32'h7FFF_FFFF, 1, 1), w);
    drain(0);
    for (int d = 1; d < 3; d++) begin
      send(d, 32'hFFFF_FFFF, 32'h1, 0, 0, mk(32'h0, 1, 0), w);
      send(d, 32'h8000_0000, 32'h1, 1, 1, mk(32'h7FFF_FFFF, 1, 1), w);
      drain(d);
    end

    for (int i = 0; i < 8; i++) begin
      send(0, 32'(i), 32'(16 * i), 0, 0, mk(32'(17 * i), 0, 0), w);
      chk("in_ready_b2b", w, 1);
    end
    drain(0);
    chk_lat = 0;

    ordy[0] = 1'b0;
    for (int i = 0; i < 4; i++)
      send(0, 32'h1000 + i, 32'h7FFF_FFF0, 0, 0,
           model(32'h1000 + i, 32'h7FFF_FFF0, 0, 0), w);
    iv[0] = 1'b1; av[0] = 32'hDEAD_BEEF; bv[0] = 32'h1234_5678;
    @(negedge clk);
    chk("stall_full_valid", ov[0], 1);
    chk("stall_in_ready", ir[0], 0);
    s_snap = sm[0]; c_snap = co[0]; o_snap = of[0];
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", ir[0], 0);
      chk("stall_out_valid", ov[0], 1);
      chk("stall_sum", sm[0], s_snap);
      chk("stall_cout", co[0], c_snap);
      chk("stall_ovf", of[0], o_snap);
    end
    @(posedge clk); #1;
    iv[0] = 1'b0;
    ordy[0] = 1'b1;
    drain(0);

    for (int i = 0; i < 3; i++)
      send(0, 32'h55 + i, 32'h1, 0, 0,
           model(32'h55 + i, 32'h1, 0, 0), w);
    rst = 1'b1;
    for (int d = 0; d < 3; d++) q[d].delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", ov[0], 0);
    chk("flush_sum", sm[0], 0);
    chk("flush_in_ready", ir[0], 1);
    repeat (10) @(negedge clk);
    chk("flush_no_stale", q[0].size(), 0);
    @(posedge clk); #1;

    for (int d = 0; d < 3; d++) rand_run(d);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pipe_adder.md
Name: pipe_adder

Overview:
Parametrised, pipelined successor to the team's combinational ripple-carry adder. Splits a SIZE-bit add/subtract into STAGES carry-chain slices with one register boundary per slice. Registered carries propagate between slices, so the critical path is one CW-bit slice rather than the full word. Uses a valid/ready stream interface on both sides, so it drops into datapaths with backpressure.

Parameters:
SIZE, 32, operand and result width in bits
STAGES, 4, number of pipeline slices; must satisfy 1 <= STAGES <= SIZE and SIZE % STAGES == 0
CW, SIZE/STAGES, derived localparam (slice width), not overridable

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  operand beat valid
in_ready  output  1  block can accept a beat this cycle
a  input  SIZE  operand A
b  input  SIZE  operand B
cin  input  1  carry-in (add mode only)
sub  input  1  0: a+b+cin; 1: a-b (cin ignored)
out_valid  output  1  result beat valid
out_ready  input  1  downstream accepts result
sum  output  SIZE  result
cout  output  1  carry-out of MSB slice (sub mode: 1 = no borrow)
ovf  output  1  two's-complement signed overflow

Behaviour:
- Only one clock and one reset: clk, plus rst (synchronous, active-high). No async logic.
- Reset:
  - All valid bits, data registers and carry registers clear to 0.
  - out_valid=0, sum=0, cout=0, ovf=0.
  - in_ready=1 in the first cycle after rst deasserts.
- Operand conditioning at input:
  - Effective B = sub ? ~b : b.
  - Effective carry-in = sub ? 1 : cin.
- Slice k (k=0..STAGES-1) adds bits [k*CW +: CW] of A and effective B, plus the registered carry from slice k-1 (the effective carry-in for k=0).
- Skew registers delay the upper operand slices until their stage.
- Deskew registers hold the lower result slices until the final stage.
- ovf = (A[MSB] == Beff[MSB]) && (sum[MSB] != A[MSB]), computed in the final stage. Carry A[MSB] and Beff[MSB] down the pipe for this.
- Global advance enable: en = !out_valid || out_ready. in_ready = en (combinational). Every stage register, including the valid bits, updates only when en=1.
- A beat is accepted when in_valid && in_ready.
- Latency: result is valid exactly STAGES cycles after acceptance, absent stalls. Throughput is 1 beat/cycle.
- Bubbles propagate as valid=0 stages; no bubble collapsing.
- Stall: while out_valid && !out_ready, the following are held bit-stable: sum, cout, ovf, out_valid. No beat is lost, duplicated or reordered.
- When en=0, in_ready=0 and inputs are ignored.
- Simultaneous output pop and input push with a full pipe is legal and sustains full rate.
- rst mid-operation discards all in-flight beats. No partial result is ever presented.
- STAGES=1: a single register stage, latency 1, functionally a registered full-width add.
- STAGES=SIZE: a bit-serial-depth pipeline with CW=1; it must elaborate and pass.
- Out-of-range or non-dividing parameters must cause an elaboration error via a generate-time check.

Decomposition:
- Shared package (adder_pkg): the operation-mode encoding constants OP_ADD=0 and OP_SUB=1, plus a function for the overflow rule, reused by future ALU blocks.
- One natural sub-module: adder_stage. It is a CW-bit slice register stage holding the sum slice, carry-out and valid, with an enable input. It is instantiated STAGES times in a generate loop.
- Skew and deskew shifting stays in the top level.

Test Plan:
1. SIZE=32, STAGES=4. a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0 -> after 4 cycles sum=0x00000000, cout=1, ovf=0. The carry ripples across all four slices.
2. a=0x7FFFFFFF, b=0x00000001, sub=0 -> sum=0x80000000, cout=0, ovf=1. Also a=0x00000003, b=0x00000004, cin=1 -> sum=0x00000008, cout=0, ovf=0.
3. sub=1 cases, each with cin=1 (cin must be ignored):
   - a=5, b=7 -> sum=0xFFFFFFFE, cout=0, ovf=0.
   - a=0x80000000, b=1 -> sum=0x7FFFFFFF, cout=1, ovf=1.
4. 8 back-to-back beats (a=i, b=0x10*i, i=0..7), out_ready=1 -> out_valid high on 8 consecutive cycles starting at cycle 4. Sums must be 0x11*i in order, and in_ready must stay 1 throughout.
5. Pipe full, out_ready=0 for 3 cycles -> in_ready=0, and sum/cout/ovf/out_valid stay bit-stable. After release, all beats drain in order with no loss or duplication.
6. Assert rst for 1 cycle with 3 beats in flight -> next cycle out_valid=0, sum=0, in_ready=1, and no stale beat appears later. Then repeat a 1000-beat random compare against a golden a±b model with random out_ready, for STAGES in {1, 4, 32}.
